// File: rtl/trace_feeder_if.sv
// trace_feeder_if: bundles the upstream trace channel and the downstream
// cache-request channel of the trace feeder.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid=1 and ready=1 are both high. A source that raises valid keeps
// valid and its payload stable until the transfer happens. The feeder's
// trace_ready does not depend on req_ready.
//
// Signals
//   trace_valid/trace_ready/trace_op/trace_addr : upstream trace records
//   req_valid/req_ready/req_op/req_addr         : downstream requests
//   req_tag/req_index/req_repeat                : decoded request fields
//
// Modports
//   master : the environment (trace source and cache stage)
//   slave  : the trace feeder
interface trace_feeder_if;
  logic        trace_valid;
  logic        trace_ready;
  logic        trace_op;
  logic [47:0] trace_addr;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [47:0] req_addr;
  logic [41:0] req_tag;
  logic [5:0]  req_index;
  logic        req_repeat;

  modport master (
    output trace_valid, trace_op, trace_addr, req_ready,
    input  trace_ready, req_valid, req_op, req_addr, req_tag, req_index,
           req_repeat
  );

  modport slave (
    input  trace_valid, trace_op, trace_addr, req_ready,
    output trace_ready, req_valid, req_op, req_addr, req_tag, req_index,
           req_repeat
  );
endinterface

// File: rtl/trace_feeder.sv
// trace_feeder: buffers memory-trace records in a circular FIFO and presents
// them one at a time to a cache stage through a single output register that
// also carries the decoded tag, set index and a repeat-address flag.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous, active-low
//   flush      : synchronous clear of FIFO, output register and last_addr
//   bus        : trace_feeder_if.slave (trace and request channels)
//   fifo_count : occupied FIFO entries (0..DEPTH), output register excluded
//   num_reads  : handed-off reads, saturating at 4095
//   num_writes : handed-off writes, saturating at 4095
//   dbg_state  : buffering FSM state (EMPTY=0, HOLD=1, STREAM=2)
module trace_feeder #(
  parameter int DEPTH     = 8,
  parameter int BLOCKSIZE = 64,
  parameter int NUMSETS   = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  trace_feeder_if.slave   bus,
  output logic [3:0]      fifo_count,
  output logic [11:0]     num_reads,
  output logic [11:0]     num_writes,
  output logic [1:0]      dbg_state
);

  // EMPTY : output register invalid. A freshly pushed record may sit in the
  //         FIFO for one cycle here before it is loaded.
  // HOLD  : output register valid, FIFO empty.
  // STREAM: output register valid, FIFO non-empty.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HOLD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int          PW      = $clog2(DEPTH);
  localparam int          BOFF    = $clog2(BLOCKSIZE);
  localparam int          ISZ     = $clog2(NUMSETS);
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);
  localparam logic [41:0] IMASK   = 42'((64'd1 << ISZ) - 64'd1);
  localparam logic [11:0] CNT_MAX = 12'hFFF;

  // FIFO storage: {op, addr}
  logic [48:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    count;
  logic [3:0]    count_nx;

  state_t        state;
  state_t        state_nx;

  // Output register
  logic          r_op;
  logic [47:0]   r_addr;
  logic [41:0]   r_tag;
  logic [5:0]    r_index;
  logic          r_repeat;

  logic [47:0]   last_addr;

  logic          active;
  logic          out_valid;
  logic          push;
  logic          handoff;
  logic          load;
  logic          valid_nx;
  logic          head_op;
  logic [47:0]   head_addr;
  logic [41:0]   tag_nx;
  logic [5:0]    index_nx;
  logic          repeat_nx;

  // Reset and flush both suppress every transfer on their edge.
  assign active          = reset && !flush;
  assign out_valid       = (state != EMPTY);
  assign bus.trace_ready = active && (count < DEPTH_C);
  assign push            = bus.trace_valid && bus.trace_ready;
  assign handoff         = active && out_valid && bus.req_ready;
  assign load            = active && (count != 4'd0) && (!out_valid || handoff);

  assign head_op   = mem[rd_ptr][48];
  assign head_addr = mem[rd_ptr][47:0];
  assign tag_nx    = 42'(head_addr >> BOFF);
  assign index_nx  = 6'(tag_nx & IMASK);
  // The address being handed off this edge becomes last_addr on the same
  // edge, so compare against it directly instead of the stale last_addr.
  assign repeat_nx = (head_addr == (handoff ? r_addr : last_addr));

  assign count_nx  = count + 4'(push) - 4'(load);
  assign valid_nx  = load || (out_valid && !handoff);

  always_comb begin
    state_nx = state;
    if (!active) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY, HOLD, STREAM: begin
          if (!valid_nx)              state_nx = EMPTY;
          else if (count_nx == 4'd0)  state_nx = HOLD;
          else                        state_nx = STREAM;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nx;
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.trace_op, bus.trace_addr};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 4'd0;
      last_addr  <= 48'd0;
      num_reads  <= 12'd0;
      num_writes <= 12'd0;
      r_op       <= 1'b0;
      r_addr     <= 48'd0;
      r_tag      <= 42'd0;
      r_index    <= 6'd0;
      r_repeat   <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= 4'd0;
      last_addr  <= 48'd0;
      r_repeat   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (load) begin
        rd_ptr   <= rd_ptr + PW'(1);
        r_op     <= head_op;
        r_addr   <= head_addr;
        r_tag    <= tag_nx;
        r_index  <= index_nx;
        r_repeat <= repeat_nx;
      end
      count <= count_nx;
      if (handoff) begin
        last_addr <= r_addr;
        if (r_op) begin
          if (num_writes != CNT_MAX) num_writes <= num_writes + 12'd1;
        end else begin
          if (num_reads != CNT_MAX) num_reads <= num_reads + 12'd1;
        end
      end
    end
  end

  assign bus.req_valid  = out_valid;
  assign bus.req_op     = r_op;
  assign bus.req_addr   = r_addr;
  assign bus.req_tag    = r_tag;
  assign bus.req_index  = r_index;
  assign bus.req_repeat = r_repeat;
  assign fifo_count     = count;
  assign dbg_state      = state;

endmodule
